fsm_seq_gen: RTL and testbench

FSM_SEQ_GEN -- requirements
Module: fsm_seq_gen

---
 rtl/fsm_seq_gen.sv | 213 +++++++++++++++++++++
 tb/tb_fsm_seq_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_gen.sv
// fsm_seq_gen - programmable pattern sequencer.
//
// Steps through a small pattern memory from index 0 up to a latched final
// index. In continuous mode it wraps, and in one-shot mode it halts on the
// last word. A done pulse marks the end of each pass. The pattern memory can
// be written at any time. A read and a write to the same word on the same
// edge return the old word.
//
// Optional feature: define FSM_SEQ_REV_EN to add the dir input. With dir=1
// latched at start, the sequence runs from the final index down to 0.
//
// Parameters
//   WIDTH  pattern word width (>=1)
//   DEPTH  pattern memory depth / maximum step count (>=2)
// Ports
//   clk      in   clock, rising edge
//   clr      in   asynchronous active-low reset (state and pattern memory)
//   start    in   begin a pass at the first step (IDLE or HALT only)
//   stop     in   abort to IDLE; wins over start and over done
//   mode     in   0 = continuous wrap, 1 = one-shot (latched at start)
//   dir      in   (FSM_SEQ_REV_EN only) 1 = count down (latched at start)
//   last     in   final step index (latched at start, clamped to DEPTH-1)
//   wr_en    in   pattern memory write strobe
//   wr_addr  in   pattern memory write address (>= DEPTH ignored)
//   wr_data  in   pattern word to write
//   x        out  registered pattern word
//   idx      out  current step index
//   busy     out  high while in RUN
//   done     out  one-cycle pulse after the final step of a pass
module fsm_seq_gen #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
`ifdef FSM_SEQ_REV_EN
  input  logic             dir,
`endif
  input  logic [AW-1:0]    last,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] x,
  output logic [AW-1:0]    idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [1:0] ACT_HOLD = 2'd0;
  localparam logic [1:0] ACT_IDLE = 2'd1;
  localparam logic [1:0] ACT_LOAD = 2'd2;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic [AW-1:0]    last_q, last_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             dir_in_s;
  logic [AW-1:0]    last_clamp_s;
  logic [AW-1:0]    load_idx_s;
  logic [AW-1:0]    term_idx_s;
  logic [AW-1:0]    wrap_idx_s;
  logic [AW-1:0]    step_idx_s;
  logic [1:0]       act_s;

`ifdef FSM_SEQ_REV_EN
  assign dir_in_s = dir;
`else
  assign dir_in_s = 1'b0;
`endif

  // Out-of-range final index only occurs when DEPTH is not a power of two.
  assign last_clamp_s = ({1'b0, last} >= DEPTH_W) ? LAST_MAX : last;

  // Direction decides which end a pass starts from, ends at and wraps to.
  assign load_idx_s = dir_in_s ? last_clamp_s : {AW{1'b0}};
  assign term_idx_s = dir_q ? {AW{1'b0}} : last_q;
  assign wrap_idx_s = dir_q ? last_q : {AW{1'b0}};
  assign step_idx_s = dir_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));

  // Next-state logic: select an action per state, then apply it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    last_d  = last_q;
    dir_d   = dir_q;
    act_s   = ACT_HOLD;

    case (state_q)
      S_IDLE: begin
        if (stop) begin
          act_s = ACT_IDLE;
        end else if (start) begin
          act_s = ACT_LOAD;
        end else begin
          act_s = ACT_IDLE;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at while running.
        if (stop) begin
          act_s = ACT_IDLE;
        end else if (idx_q == term_idx_s) begin
          done_d = 1'b1;
          if (mode_q) begin
            // One-shot: x and idx keep the final word and index.
            state_d = S_HALT;
          end else begin
            idx_d = wrap_idx_s;
            x_d   = mem_q[wrap_idx_s];
          end
        end else begin
          idx_d = step_idx_s;
          x_d   = mem_q[step_idx_s];
        end
      end
      S_HALT: begin
        if (stop) begin
          act_s = ACT_IDLE;
        end else if (start) begin
          act_s = ACT_LOAD;
        end else begin
          act_s = ACT_HOLD;
        end
      end
      default: begin
        act_s = ACT_IDLE;
      end
    endcase

    case (act_s)
      ACT_IDLE: begin
        state_d = S_IDLE;
        idx_d   = {AW{1'b0}};
        x_d     = {WIDTH{1'b0}};
        done_d  = 1'b0;
      end
      ACT_LOAD: begin
        state_d = S_RUN;
        mode_d  = mode;
        last_d  = last_clamp_s;
        dir_d   = dir_in_s;
        idx_d   = load_idx_s;
        x_d     = mem_q[load_idx_s];
      end
      default: begin
        act_s = ACT_HOLD;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      idx_q   <= {AW{1'b0}};
      x_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      last_q  <= {AW{1'b0}};
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
    end
  end

  // Pattern memory. Reads above sample the old contents (read-before-write).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign x    = x_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen. Two instances share most inputs:
// u_dut (DEPTH=4) and u_dut3 (DEPTH=3). u_dut3 exercises clamping of the
// final index and rejection of out-of-range writes. Each directed row pushes
// the expected outputs for the coming edge. A monitor process pops and
// compares the expected outputs one step after that edge.
module tb_fsm_seq_gen;

  typedef struct {
    logic       x;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    int         sel;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_sel  = 0;
  int   step_n   = 0;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] last = 2'd0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic       wr_data = 1'b0;
  logic       x, x3, busy, busy3, done, done3;
  logic [1:0] idx, idx3;
`ifdef FSM_SEQ_REV_EN
  logic       dir = 1'b0;
`endif

  always #5 clk = ~clk;

  fsm_seq_gen #(.WIDTH(1), .DEPTH(4)) u_dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
`ifdef FSM_SEQ_REV_EN
    .dir     (dir),
`endif
    .last    (last),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .x       (x),
    .idx     (idx),
    .busy    (busy),
    .done    (done)
  );

  fsm_seq_gen #(.WIDTH(1), .DEPTH(3)) u_dut3 (
    .clk     (clk),
    .clr     (clr),
    .start   (start3),
    .stop    (stop),
    .mode    (mode),
`ifdef FSM_SEQ_REV_EN
    .dir     (dir),
`endif
    .last    (last),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .x       (x3),
    .idx     (idx3),
    .busy    (busy3),
    .done    (done3)
  );

  // One stimulus row: drive inputs at the falling edge and queue what the
  // selected instance must show after the next rising edge.
  task automatic cyc(input logic st, input logic sp, input logic md,
                     input logic [1:0] ls, input logic we, input logic [1:0] wa,
                     input logic wd, input logic ex, input logic [1:0] ei,
                     input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    start   = (cur_sel == 0) ? st : 1'b0;
    start3  = (cur_sel == 1) ? st : 1'b0;
    stop    = sp;
    mode    = md;
    last    = ls;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    e.x = ex; e.idx = ei; e.busy = eb; e.done = ed;
    e.sel = cur_sel; e.tag = step_n;
    step_n++;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the queued expectation one step after each rising edge.
  initial begin
    exp_t       e;
    logic       ax, ab, ad;
    logic [1:0] ai;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.sel == 0) begin
          ax = x;  ai = idx;  ab = busy;  ad = done;
        end else begin
          ax = x3; ai = idx3; ab = busy3; ad = done3;
        end
        checks++;
        if (ax !== e.x || ai !== e.idx || ab !== e.busy || ad !== e.done) begin
          failures++;
          $display("FAIL row%0d dut%0d got x=%0d idx=%0d busy=%0d done=%0d want x=%0d idx=%0d busy=%0d done=%0d",
                   e.tag, e.sel, ax, ai, ab, ad, e.x, e.idx, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    // Reset state while clr is low.
    #2;
    checks++;
    if ({x, idx, busy, done, x3, idx3, busy3, done3} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state got %b want 0", {x, idx, busy, done, x3, idx3, busy3, done3});
    end
    @(negedge clk);
    clr = 1'b1;

    //   st sp md last   we addr  wd  |  x  idx  busy done
    // Load pattern {0,1,1,1}; addr 3 is out of range for u_dut3.
    cyc(1'b0,1'b0,1'b0,2'd0, 1'b1,2'd1,1'b1, 1'b0,2'd0,1'b0,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd0, 1'b1,2'd2,1'b1, 1'b0,2'd0,1'b0,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd0, 1'b1,2'd3,1'b1, 1'b0,2'd0,1'b0,1'b0);
    // Continuous, last=3; mode/last change mid-run must not matter.
    cyc(1'b1,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd1, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd1, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd1, 1'b0,2'd0,1'b0, 1'b1,2'd3,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd1, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b1);
    cyc(1'b0,1'b0,1'b1,2'd1, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0);
    // start while running is ignored.
    cyc(1'b1,1'b0,1'b1,2'd1, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0);
    // stop and start together at idx 2.
    cyc(1'b1,1'b1,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    // One-shot, last=2: halt holding 1, single done.
    cyc(1'b1,1'b0,1'b1,2'd2, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd2, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd2, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd2, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b0,1'b1);
    cyc(1'b0,1'b0,1'b1,2'd2, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b0,1'b0);
    // Restart from HALT as one-shot, last=0, then stop in HALT.
    cyc(1'b1,1'b0,1'b1,2'd0, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b1,2'd0, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b1);
    cyc(1'b0,1'b1,1'b0,2'd0, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    // DEPTH=3 instance: last=3 clamps to 2; its memory is {0,1,1}.
    cur_sel = 1;
    cyc(1'b1,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b1);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b1,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    cur_sel = 0;
    // Write mem[1]=0 as idx goes 0->1: old word now, new word next pass.
    cyc(1'b1,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b1,2'd1,1'b0, 1'b1,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd3,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b1);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b1,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    // mem[0]=1, then last=0 continuous: x=1 constant, done every cycle.
    cyc(1'b0,1'b0,1'b0,2'd0, 1'b1,2'd0,1'b1, 1'b0,2'd0,1'b0,1'b0);
    cyc(1'b1,1'b0,1'b0,2'd0, 1'b0,2'd0,1'b0, 1'b1,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,1'b0, 1'b1,2'd0,1'b1,1'b1);
    cyc(1'b0,1'b0,1'b0,2'd0, 1'b0,2'd0,1'b0, 1'b1,2'd0,1'b1,1'b1);
    // stop beats done generation.
    cyc(1'b0,1'b1,1'b0,2'd0, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    // Memory is now {1,0,1,1}; run, then clr mid-run.
    cyc(1'b1,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0);
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    checks++;
    if ({x, idx, busy, done} !== 5'd0) begin
      failures++;
      $display("FAIL async_clr got %b want 00000", {x, idx, busy, done});
    end
    @(negedge clk);
    clr = 1'b1;
    // After reset the memory is all zero and the pass restarts at step 0.
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);
    cyc(1'b1,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd1,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd2,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd3,1'b1,1'b0);
    cyc(1'b0,1'b0,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b1);
    cyc(1'b0,1'b1,1'b0,2'd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
